// File: rtl/host_load_port.sv
// host_load_port: responder side of the byte-wide host pin protocol.
// Decodes command/address/data bytes from an external host. Issues single-cycle
// reads and writes to the CPU memory. Owns the CPU run/halt control.
//
// Handshake (4-phase strobe/ack): the host places a byte on host_data and raises
// host_stb. After synchronization the byte is captured once, and host_ack is
// raised. For a READ address byte, ack is raised only when host_rdata is valid.
// The host then drops host_stb, and host_ack falls on the first edge where the
// synchronized strobe is low. A new byte is accepted only while ack is low, so
// a strobe held high can never be captured twice.
module host_load_port #(
  parameter int ADDR_W        = 8,
  parameter bit HALT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_data,
  input  logic              host_stb,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              cmd_err,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_RUN   = 8'h03;
  localparam logic [7:0] OP_HALT  = 8'h04;

  typedef enum logic [2:0] {CMD, ADDR, DATA, RD_ISSUE, RD_WAIT} state_t;

  state_t state, state_n;
  logic   op_rd, op_rd_n;
  logic   stb_m, stb_s;
  logic   capture;
  logic   ack_set, err_set, err_clr, run_set, halt_set;
  logic   addr_ld, wdata_ld, rdata_ld, we_set, re_set;

  // Two-flop synchronizer for the asynchronous host strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_m <= 1'b0;
      stb_s <= 1'b0;
    end else begin
      stb_m <= host_stb;
      stb_s <= stb_m;
    end
  end

  // A byte is taken only in a byte-accepting state, with the strobe up and ack down.
  assign capture = stb_s && !host_ack &&
                   (state == CMD || state == ADDR || state == DATA);

  // State register: FSM state and the latched operation (read vs write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CMD;
      op_rd <= 1'b0;
    end else begin
      state <= state_n;
      op_rd <= op_rd_n;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_n  = state;
    op_rd_n  = op_rd;
    ack_set  = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    run_set  = 1'b0;
    halt_set = 1'b0;
    addr_ld  = 1'b0;
    wdata_ld = 1'b0;
    rdata_ld = 1'b0;
    we_set   = 1'b0;
    re_set   = 1'b0;
    case (state)
      CMD: begin
        if (capture) begin
          ack_set = 1'b1;
          case (host_data)
            OP_WRITE: begin state_n = ADDR; op_rd_n = 1'b0; err_clr = 1'b1; end
            OP_READ:  begin state_n = ADDR; op_rd_n = 1'b1; err_clr = 1'b1; end
            OP_RUN:   begin run_set  = 1'b1; err_clr = 1'b1; end
            OP_HALT:  begin halt_set = 1'b1; err_clr = 1'b1; end
            default:  err_set = 1'b1;
          endcase
        end
      end
      ADDR: begin
        if (capture) begin
          addr_ld = 1'b1;
          if (op_rd) begin
            // Ack is withheld until the read data has been returned.
            re_set  = 1'b1;
            state_n = RD_ISSUE;
          end else begin
            ack_set = 1'b1;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (capture) begin
          wdata_ld = 1'b1;
          we_set   = 1'b1;
          ack_set  = 1'b1;
          state_n  = CMD;
        end
      end
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: begin
        rdata_ld = 1'b1;
        ack_set  = 1'b1;
        state_n  = CMD;
      end
      default: state_n = CMD;
    endcase
  end

  // Handshake acknowledge: raised by the FSM, released once the strobe is seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_ack <= 1'b0;
    end else if (ack_set) begin
      host_ack <= 1'b1;
    end else if (host_ack && !stb_s) begin
      host_ack <= 1'b0;
    end
  end

  // Memory interface: held address/data, one-cycle read and write pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      if (addr_ld)  mem_addr  <= host_data[ADDR_W-1:0];
      if (wdata_ld) mem_wdata <= host_data;
      mem_we <= we_set;
      mem_re <= re_set;
    end
  end

  // Host-visible status: read-back byte, sticky command error, CPU halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata <= 8'h00;
      cmd_err    <= 1'b0;
      cpu_halt   <= HALT_ON_RESET;
    end else begin
      if (rdata_ld) host_rdata <= mem_rdata;
      if (err_set)      cmd_err <= 1'b1;
      else if (err_clr) cmd_err <= 1'b0;
      if (run_set)       cpu_halt <= 1'b0;
      else if (halt_set) cpu_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_host_load_port.sv
// Directed bench for host_load_port: host byte protocol, memory model, scoreboard.
module tb_host_load_port;

  logic       clk;
  logic       rst;
  logic [7:0] host_data;
  logic       host_stb;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       cmd_err;
  logic       cpu_halt;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  host_load_port #(.ADDR_W(8), .HALT_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_data  (host_data),
    .host_stb   (host_stb),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .cmd_err    (cmd_err),
    .cpu_halt   (cpu_halt),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'hEE;
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // ---------------- pulse monitor ----------------
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] we_addr, we_data, re_addr;

  always @(negedge clk) begin
    if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
    if (mem_re) begin re_cnt++; re_addr = mem_addr; end
    if (mem_we && mem_re) both_cnt++;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic [7:0] ack_rdata;
  logic       ack_halt;
  logic       ack_err;

  // One full 4-phase byte transfer; checks rise and fall latency of ack.
  task automatic send_byte(input logic [7:0] b, input int lat, input int hold, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    host_data = b;
    host_stb  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!host_ack && n < 30);
    chk("ack_rise_lat", n, lat);
    ack_rdata = host_rdata;
    ack_halt  = cpu_halt;
    ack_err   = cmd_err;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("ack_held", host_ack, 1'b1);
    end
    host_stb = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (host_ack && n < 30);
    chk("ack_fall_lat", n, 3);
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] sb [256];
  logic [7:0] wa[$];

  // ---------------- stimulus ----------------
  int we0, re0;

  initial begin
    rst       = 1'b1;
    host_stb  = 1'b0;
    host_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt",  cpu_halt,   1'b1);
    chk("rst_ack",   host_ack,   1'b0);
    chk("rst_we",    mem_we,     1'b0);
    chk("rst_re",    mem_re,     1'b0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_err",   cmd_err,    1'b0);
    chk("rst_addr",  mem_addr,   8'h00);
    rst = 1'b0;

    // WRITE 0x10 <- 0xA5
    we0 = we_cnt;
    send_byte(8'h01, 3, 0, 1);
    send_byte(8'h10, 3, 0, 0);
    chk("wr_addr_held", mem_addr, 8'h10);
    send_byte(8'hA5, 3, 0, 0);
    chk("wr_pulses", we_cnt - we0, 1);
    chk("wr_addr",   we_addr, 8'h10);
    chk("wr_data",   we_data, 8'hA5);

    // READ 0x10 with memory now holding 0x5A
    mem[8'h10] = 8'h5A;
    re0 = re_cnt;
    send_byte(8'h02, 3, 0, 0);
    send_byte(8'h10, 5, 0, 0);
    chk("rd_data_at_ack", ack_rdata, 8'h5A);
    chk("rd_pulses", re_cnt - re0, 1);
    chk("rd_addr", re_addr, 8'h10);

    // RUN then HALT: no memory activity
    we0 = we_cnt; re0 = re_cnt;
    chk("pre_run_halt", cpu_halt, 1'b1);
    send_byte(8'h03, 3, 0, 0);
    chk("run_halt", ack_halt, 1'b0);
    send_byte(8'h04, 3, 0, 0);
    chk("halt_halt", ack_halt, 1'b1);
    chk("runhalt_we", we_cnt - we0, 0);
    chk("runhalt_re", re_cnt - re0, 0);

    // Unknown command, then WRITE clears the error
    send_byte(8'h7F, 3, 0, 0);
    chk("bad_err", ack_err, 1'b1);
    chk("bad_halt", cpu_halt, 1'b1);
    chk("bad_we", we_cnt - we0, 0);
    send_byte(8'h01, 3, 0, 0);
    chk("err_clear", ack_err, 1'b0);
    send_byte(8'h00, 3, 0, 0);
    send_byte(8'h00, 3, 0, 0);
    chk("wr0_pulses", we_cnt - we0, 1);
    chk("wr0_addr", we_addr, 8'h00);
    chk("wr0_data", we_data, 8'h00);
    chk("rdata_hold", host_rdata, 8'h5A);

    // Reset while the WRITE address byte is acknowledged with stb high
    begin
      int n;
      we0 = we_cnt;
      send_byte(8'h01, 3, 0, 0);
      host_data = 8'h10;
      host_stb  = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!host_ack && n < 30);
      chk("rstx_ack_before", host_ack, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rstx_ack_async", host_ack, 1'b0);
      chk("rstx_we", mem_we, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!host_ack && n < 30);
      chk("rstx_recap_lat", n, 3);
      chk("rstx_cmd_err", cmd_err, 1'b1);
      host_stb = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (host_ack && n < 30);
      chk("rstx_fall_lat", n, 3);
      repeat (4) @(posedge clk);
      #1;
      chk("rstx_no_we", we_cnt - we0, 0);
    end

    // 64 random WRITE/READ pairs with random strobe timing
    for (int i = 0; i < 256; i++) sb[i] = mem[i];
    we0 = we_cnt; re0 = re_cnt;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] a, d, ra;
      int h;
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      h = (k % 8 == 3) ? 20 : int'($urandom_range(0, 3));
      send_byte(8'h01, 3, $urandom_range(0, 2), $urandom_range(0, 3));
      send_byte(a,     3, h,                    $urandom_range(0, 3));
      send_byte(d,     3, $urandom_range(0, 2), $urandom_range(0, 3));
      sb[a] = d;
      wa.push_back(a);
      ra = wa[$urandom_range(0, wa.size() - 1)];
      exp_q.push_back(sb[ra]);
      send_byte(8'h02, 3, $urandom_range(0, 2), $urandom_range(0, 3));
      send_byte(ra,    5, h,                    $urandom_range(0, 3));
      chk("rand_rdata", ack_rdata, exp_q.pop_front());
    end
    chk("rand_we_count", we_cnt - we0, 64);
    chk("rand_re_count", re_cnt - re0, 64);
    chk("we_re_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end, expected end of test");
    $fatal(1, "time limit reached");
  end

endmodule
